// File: rtl/csr_mtrap_unit_if.sv
// Execute-stage CSR/trap bus between the pipeline and csr_mtrap_unit.
// master: pipeline side driving CSR ops, retire/exception/mret and interrupt lines; slave: the CSR unit.
interface csr_mtrap_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            csr_en;
    logic            csr_we;
    logic [2:0]      funct3;
    logic [11:0]     addr;
    logic [XLEN-1:0] data_in;
    logic [XLEN-1:0] data_out;
    logic            illegal;
    logic [XLEN-1:0] pc_in;
    logic            retire;
    logic            exc_valid;
    logic [3:0]      exc_cause;
    logic [XLEN-1:0] exc_tval;
    logic            mret;
    logic            irq_soft;
    logic            irq_timer;
    logic            irq_ext;
    logic            trap;
    logic            redirect;
    logic [XLEN-1:0] pc_out;

    modport master (
        output csr_en, csr_we, funct3, addr, data_in, pc_in, retire,
               exc_valid, exc_cause, exc_tval, mret, irq_soft, irq_timer, irq_ext,
        input  data_out, illegal, trap, redirect, pc_out
    );

    modport slave (
        input  csr_en, csr_we, funct3, addr, data_in, pc_in, retire,
               exc_valid, exc_cause, exc_tval, mret, irq_soft, irq_timer, irq_ext,
        output data_out, illegal, trap, redirect, pc_out
    );
endinterface

// File: rtl/csr_mtrap_unit.sv
// Machine-mode CSR file and trap controller with 64-bit counters and three level interrupts.
// Optional CSR_VECTORED_EN: writable mtvec mode with vectored interrupt targets (default: direct only).
module csr_mtrap_unit #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned HART_ID  = 0,
    parameter logic [31:0] MISA_VAL = 32'h40000100
) (
    input  logic             clock_i,
    input  logic             reset_i,
    csr_mtrap_unit_if.slave  csr_if
);
    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MISA      = 12'h301;
    localparam logic [11:0] A_MIE       = 12'h304;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MTVAL     = 12'h343;
    localparam logic [11:0] A_MIP       = 12'h344;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_CYCLE     = 12'hC00;
    localparam logic [11:0] A_INSTRET   = 12'hC02;
    localparam logic [11:0] A_CYCLEH    = 12'hC80;
    localparam logic [11:0] A_INSTRETH  = 12'hC82;
    localparam logic [11:0] A_MVENDORID = 12'hF11;
    localparam logic [11:0] A_MARCHID   = 12'hF12;
    localparam logic [11:0] A_MIMPID    = 12'hF13;
    localparam logic [11:0] A_MHARTID   = 12'hF14;

    localparam bit IS_RV32 = (XLEN == 32);
    localparam logic [XLEN-1:0] MISA_RD = (XLEN == 64) ?
        XLEN'({2'b10, 36'd0, MISA_VAL[25:0]}) : XLEN'(MISA_VAL);

    // Interrupt bits are kept packed as {ext, timer, soft} and spread to b11/b7/b3 on read.
    function automatic logic [11:0] irq_vec(input logic [2:0] v);
        return {v[2], 3'b000, v[1], 3'b000, v[0], 3'b000};
    endfunction

    logic            mstatus_mie_q, mstatus_mie_d;
    logic            mstatus_mpie_q, mstatus_mpie_d;
    logic [2:0]      mie_q, mie_d;
    logic [2:0]      mip_q, mip_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mscratch_q, mscratch_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic [XLEN-1:0] mtval_q, mtval_d;
    logic [63:0]     mcycle_q, mcycle_d;
    logic [63:0]     minstret_q, minstret_d;

    logic [XLEN-1:0] rdata_s;
    logic [XLEN-1:0] wdata_s;
    logic [XLEN-1:0] mtvec_wr_s;
    logic [XLEN-1:0] base_s;
    logic [XLEN-1:0] target_s;
    logic [XLEN-1:0] cause_s;
    logic [XLEN-1:0] epc_s;
    logic [63:0]     mcycle_inc_s;
    logic [63:0]     minstret_inc_s;
    logic [2:0]      pend_s;
    logic [3:0]      irq_code_s;
    logic            known_s;
    logic            ro_s;
    logic            illegal_s;
    logic            irq_take_s;
    logic            trap_s;
    logic            mret_ok_s;
    logic            do_write_s;

    // CSR read mux, address decode and read-only classification.
    always_comb begin
        rdata_s = '0;
        known_s = 1'b1;
        ro_s    = 1'b0;
        case (csr_if.addr)
            A_MSTATUS:  rdata_s = XLEN'({2'b11, 3'b000, mstatus_mpie_q, 3'b000, mstatus_mie_q, 3'b000});
            A_MISA:     begin rdata_s = MISA_RD; ro_s = 1'b1; end
            A_MIE:      rdata_s = XLEN'(irq_vec(mie_q));
            A_MIP:      begin rdata_s = XLEN'(irq_vec(mip_q)); ro_s = 1'b1; end
            A_MTVEC:    rdata_s = mtvec_q;
            A_MSCRATCH: rdata_s = mscratch_q;
            A_MEPC:     rdata_s = mepc_q;
            A_MCAUSE:   rdata_s = mcause_q;
            A_MTVAL:    rdata_s = mtval_q;
            A_MCYCLE, A_CYCLE:     rdata_s = XLEN'(mcycle_q);
            A_MINSTRET, A_INSTRET: rdata_s = XLEN'(minstret_q);
            A_MCYCLEH, A_CYCLEH: begin
                if (IS_RV32) rdata_s = XLEN'(mcycle_q[63:32]);
                else         known_s = 1'b0;
            end
            A_MINSTRETH, A_INSTRETH: begin
                if (IS_RV32) rdata_s = XLEN'(minstret_q[63:32]);
                else         known_s = 1'b0;
            end
            A_MVENDORID, A_MARCHID, A_MIMPID: rdata_s = '0;
            A_MHARTID:  rdata_s = XLEN'(HART_ID);
            default:    known_s = 1'b0;
        endcase
        // The 0xCxx/0xFxx address quadrant is read-only by encoding.
        if (csr_if.addr[11:10] == 2'b11) ro_s = 1'b1;
        else                             ro_s = ro_s;
    end

    // Read-modify-write value and the legal forms of an mtvec write.
    always_comb begin
        case (csr_if.funct3[1:0])
            2'b01:   wdata_s = csr_if.data_in;
            2'b10:   wdata_s = rdata_s | csr_if.data_in;
            2'b11:   wdata_s = rdata_s & ~csr_if.data_in;
            default: wdata_s = rdata_s;
        endcase
`ifdef CSR_VECTORED_EN
        mtvec_wr_s = {wdata_s[XLEN-1:2], (wdata_s[1:0] == 2'b01) ? 2'b01 : 2'b00};
`else
        mtvec_wr_s = {wdata_s[XLEN-1:2], 2'b00};
`endif
    end

    // Trap arbitration: exception over interrupt over mret over CSR write.
    always_comb begin
        pend_s     = mip_q & mie_q & {3{mstatus_mie_q}};
        irq_take_s = csr_if.retire & ~csr_if.exc_valid & (|pend_s);
        trap_s     = csr_if.exc_valid | irq_take_s;
        mret_ok_s  = csr_if.mret & ~trap_s;
        illegal_s  = csr_if.csr_en & (~known_s | (csr_if.csr_we & ro_s));
        do_write_s = csr_if.csr_en & csr_if.csr_we & ~illegal_s & ~trap_s & ~mret_ok_s;
        if (pend_s[2])      irq_code_s = 4'd11;
        else if (pend_s[0]) irq_code_s = 4'd3;
        else                irq_code_s = 4'd7;
        cause_s = '0;
        if (csr_if.exc_valid) begin
            cause_s = XLEN'(csr_if.exc_cause);
            epc_s   = csr_if.pc_in;
        end else begin
            cause_s         = XLEN'(irq_code_s);
            cause_s[XLEN-1] = 1'b1;
            epc_s           = csr_if.pc_in + {{(XLEN-3){1'b0}}, 3'b100};
        end
        base_s = {mtvec_q[XLEN-1:2], 2'b00};
`ifdef CSR_VECTORED_EN
        if (irq_take_s && (mtvec_q[1:0] == 2'b01)) target_s = base_s + XLEN'({irq_code_s, 2'b00});
        else                                       target_s = base_s;
`else
        target_s = base_s;
`endif
    end

    // Next-state for all architectural state; counter writes override that cycle's increment.
    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_d          = mie_q;
        mip_d          = {csr_if.irq_ext, csr_if.irq_timer, csr_if.irq_soft};
        mtvec_d        = mtvec_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mtval_d        = mtval_q;
        mcycle_inc_s   = mcycle_q + 64'd1;
        minstret_inc_s = minstret_q + {63'd0, csr_if.retire & ~trap_s};
        mcycle_d       = mcycle_inc_s;
        minstret_d     = minstret_inc_s;
        if (trap_s) begin
            mepc_d         = {epc_s[XLEN-1:2], 2'b00};
            mcause_d       = cause_s;
            mtval_d        = csr_if.exc_valid ? csr_if.exc_tval : '0;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else if (mret_ok_s) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end else if (do_write_s) begin
            case (csr_if.addr)
                A_MSTATUS: begin
                    mstatus_mie_d  = wdata_s[3];
                    mstatus_mpie_d = wdata_s[7];
                end
                A_MIE:      mie_d      = {wdata_s[11], wdata_s[7], wdata_s[3]};
                A_MTVEC:    mtvec_d    = mtvec_wr_s;
                A_MSCRATCH: mscratch_d = wdata_s;
                A_MEPC:     mepc_d     = {wdata_s[XLEN-1:2], 2'b00};
                A_MCAUSE:   mcause_d   = wdata_s;
                A_MTVAL:    mtval_d    = wdata_s;
                A_MCYCLE: begin
                    if (IS_RV32) mcycle_d = {mcycle_inc_s[63:32], wdata_s[31:0]};
                    else         mcycle_d = 64'(wdata_s);
                end
                A_MINSTRET: begin
                    if (IS_RV32) minstret_d = {minstret_inc_s[63:32], wdata_s[31:0]};
                    else         minstret_d = 64'(wdata_s);
                end
                A_MCYCLEH: begin
                    if (IS_RV32) mcycle_d = {wdata_s[31:0], mcycle_inc_s[31:0]};
                    else         mcycle_d = mcycle_inc_s;
                end
                A_MINSTRETH: begin
                    if (IS_RV32) minstret_d = {wdata_s[31:0], minstret_inc_s[31:0]};
                    else         minstret_d = minstret_inc_s;
                end
                default:    mscratch_d = mscratch_q;
            endcase
        end else begin
            mscratch_d = mscratch_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= 3'b000;
            mip_q          <= 3'b000;
            mtvec_q        <= '0;
            mscratch_q     <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
            mtval_q        <= '0;
            mcycle_q       <= 64'd0;
            minstret_q     <= 64'd0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_q          <= mie_d;
            mip_q          <= mip_d;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mtval_q        <= mtval_d;
            mcycle_q       <= mcycle_d;
            minstret_q     <= minstret_d;
        end
    end

    assign csr_if.data_out = rdata_s;
    assign csr_if.illegal  = illegal_s;
    assign csr_if.trap     = trap_s;
    assign csr_if.redirect = trap_s | mret_ok_s;
    assign csr_if.pc_out   = trap_s ? target_s : mepc_q;
endmodule
